// File: rtl/comparator_pkg.sv
// Shared constants for the three-input maximum selector: one-hot winner codes,
// the two-bit pair-stage index, and the default operand width.
package comparator_pkg;

    localparam int unsigned COMP_WIDTH_DEFAULT = 22;

    localparam logic [2:0] IDX_NONE = 3'b000;
    localparam logic [2:0] IDX_A    = 3'b001;
    localparam logic [2:0] IDX_B    = 3'b010;
    localparam logic [2:0] IDX_C    = 3'b100;

    // Index of the A/B pair winner, one-hot over {B, A}.
    typedef logic [1:0] ab_idx_t;
    localparam ab_idx_t AB_IDX_A = 2'b01;
    localparam ab_idx_t AB_IDX_B = 2'b10;

    function automatic ab_idx_t ab_idx_from_sel(input logic sel);
        return sel ? AB_IDX_B : AB_IDX_A;
    endfunction

    // C only wins when strictly greater than the pair winner.
    function automatic logic [2:0] onehot_winner(input ab_idx_t ab_idx, input logic fin_sel);
        return fin_sel ? IDX_C : {1'b0, ab_idx};
    endfunction

endpackage

// File: rtl/cmp_max2.sv
// Combinational two-operand unsigned maximum; sel = 0 when the first operand
// wins, including ties.
module cmp_max2
    import comparator_pkg::*;
#(
    parameter int unsigned p_width = COMP_WIDTH_DEFAULT
) (
    input  logic [p_width-1:0] i_x,
    input  logic [p_width-1:0] i_y,
    output logic [p_width-1:0] o_max,
    output logic               o_sel
);

    always_comb begin
        o_sel = (i_x < i_y);
        o_max = o_sel ? i_y : i_x;
    end

endmodule

// File: rtl/comparator_3in_max.sv
// Registered three-input unsigned max with one-hot winner (A > B > C on ties).
// Define COMPARATOR_3IN_PIPE_EN to register the A/B stage (latency 2).
module comparator_3in_max
    import comparator_pkg::*;
#(
    parameter int unsigned p_width = COMP_WIDTH_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [p_width-1:0] i_a,
    input  logic [p_width-1:0] i_b,
    input  logic [p_width-1:0] i_c,
    output logic [p_width-1:0] o_result,
    output logic [3:1]         o_index
);

    logic [p_width-1:0] ab_max;
    logic               ab_sel;
    logic [p_width-1:0] ab_val_s;
    ab_idx_t            ab_idx_s;
    logic [p_width-1:0] c_s;
    logic [p_width-1:0] fin_max;
    logic               fin_sel;

    logic [p_width-1:0] result_d, result_q;
    logic [3:1]         index_d,  index_q;

    cmp_max2 #(.p_width(p_width)) u_cmp_ab (
        .i_x   (i_a),
        .i_y   (i_b),
        .o_max (ab_max),
        .o_sel (ab_sel)
    );

`ifdef COMPARATOR_3IN_PIPE_EN
    logic [p_width-1:0] ab_val_d, ab_val_q;
    ab_idx_t            ab_idx_d, ab_idx_q;
    logic [p_width-1:0] c_d,      c_q;

    always_comb begin
        ab_val_d = ab_max;
        ab_idx_d = ab_idx_from_sel(ab_sel);
        c_d      = i_c;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ab_val_q <= '0;
            ab_idx_q <= AB_IDX_A;
            c_q      <= '0;
        end else begin
            ab_val_q <= ab_val_d;
            ab_idx_q <= ab_idx_d;
            c_q      <= c_d;
        end
    end

    always_comb begin
        ab_val_s = ab_val_q;
        ab_idx_s = ab_idx_q;
        c_s      = c_q;
    end
`else
    always_comb begin
        ab_val_s = ab_max;
        ab_idx_s = ab_idx_from_sel(ab_sel);
        c_s      = i_c;
    end
`endif

    cmp_max2 #(.p_width(p_width)) u_cmp_fin (
        .i_x   (ab_val_s),
        .i_y   (c_s),
        .o_max (fin_max),
        .o_sel (fin_sel)
    );

    always_comb begin
        result_d = fin_max;
        index_d  = onehot_winner(ab_idx_s, fin_sel);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= '0;
            index_q  <= IDX_NONE;
        end else begin
            result_q <= result_d;
            index_q  <= index_d;
        end
    end

    assign o_result = result_q;
    assign o_index  = index_q;

endmodule

// File: tb/tb_comparator_3in_max.sv
// Directed self-checking bench for comparator_3in_max; expected values are
// hand-computed from the tie rule A > B > C.
module tb_comparator_3in_max;

    localparam int unsigned P_W = 22;
`ifdef COMPARATOR_3IN_PIPE_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    typedef struct {
        logic [P_W-1:0] a;
        logic [P_W-1:0] b;
        logic [P_W-1:0] c;
        logic [P_W-1:0] r;
        logic [2:0]     idx;
    } vec_t;

    logic           clk;
    logic           rst_n;
    logic [P_W-1:0] a, b, c;
    logic [P_W-1:0] result;
    logic [3:1]     index;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    vec_t        vecs[12];

    comparator_3in_max #(.p_width(P_W)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_a      (a),
        .i_b      (b),
        .i_c      (c),
        .o_result (result),
        .o_index  (index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        a = v.a;
        b = v.b;
        c = v.c;
    endtask

    initial begin
        vecs[0]  = '{22'd3,       22'd2,       22'd1,       22'd3,       3'b001};
        vecs[1]  = '{22'd6,       22'd7,       22'd4,       22'd7,       3'b010};
        vecs[2]  = '{22'd5,       22'd4,       22'd7,       22'd7,       3'b100};
        vecs[3]  = '{22'd10,      22'd11,      22'd11,      22'd11,      3'b010};
        vecs[4]  = '{22'd12,      22'd12,      22'd11,      22'd12,      3'b001};
        vecs[5]  = '{22'd15,      22'd15,      22'd16,      22'd16,      3'b100};
        vecs[6]  = '{22'd18,      22'd18,      22'd18,      22'd18,      3'b001};
        vecs[7]  = '{22'd21,      22'd20,      22'd21,      22'd21,      3'b001};
        vecs[8]  = '{22'd32,      22'd33,      22'd33,      22'd33,      3'b010};
        vecs[9]  = '{22'd0,       22'h3FFFFF,  22'h3FFFFF,  22'h3FFFFF,  3'b010};
        vecs[10] = '{22'h3FFFFF,  22'd0,       22'd0,       22'h3FFFFF,  3'b001};
        vecs[11] = '{22'd0,       22'd0,       22'd0,       22'd0,       3'b001};

        // Reset with all-zero operands, released between edges.
        rst_n = 1'b0;
        a = '0; b = '0; c = '0;
        #3;
        check_eq("rst_result_pre", 64'(result), 64'd0);
        check_eq("rst_index_pre",  64'(index),  64'd0);
        #5;
        check_eq("rst_result_edge", 64'(result), 64'd0);
        check_eq("rst_index_edge",  64'(index),  64'd0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_result", 64'(result), 64'd0);
        check_eq("post_rst_index",  64'(index),  64'b001);

        // Each vector held long enough to settle through the full latency.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            repeat (LAT) @(posedge clk);
            #1;
            check_eq($sformatf("hold_result_%0d", i), 64'(result), 64'(vecs[i].r));
            check_eq($sformatf("hold_index_%0d", i),  64'(index),  64'(vecs[i].idx));
        end

        // Inputs changed mid-cycle must not disturb the registered outputs.
        #3;
        drive(vecs[1]);
        #1;
        check_eq("midcycle_result", 64'(result), 64'(vecs[11].r));
        check_eq("midcycle_index",  64'(index),  64'(vecs[11].idx));
        @(posedge clk); #1;

        // New operands every cycle: outputs trail inputs by exactly LAT edges.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            @(posedge clk); #1;
            check_eq($sformatf("stream_onehot_%0d", i), 64'($countones(index)), 64'd1);
            if (i >= int'(LAT) - 1) begin
                check_eq($sformatf("stream_result_%0d", i), 64'(result), 64'(vecs[i - int'(LAT) + 1].r));
                check_eq($sformatf("stream_index_%0d", i),  64'(index),  64'(vecs[i - int'(LAT) + 1].idx));
            end
        end

        // Mid-run reset pulse between edges clears outputs without a clock.
        a = 22'd33; b = 22'd33; c = 22'd33;
        repeat (LAT) @(posedge clk);
        #1;
        check_eq("pre_pulse_result", 64'(result), 64'd33);
        check_eq("pre_pulse_index",  64'(index),  64'b001);
        #1 rst_n = 1'b0;
        #1;
        check_eq("pulse_result", 64'(result), 64'd0);
        check_eq("pulse_index",  64'(index),  64'd0);
        #2 rst_n = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        check_eq("recover_result", 64'(result), 64'd33);
        check_eq("recover_index",  64'(index),  64'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comparator_3in_max.md
Name: comparator_3in_max

Overview:
- Registered three-input unsigned maximum selector for winner-take-all stages, such as picking the strongest neuron or score among three candidates.
- Outputs the largest of three p_width-bit operands and a one-hot index of the winning input.
- Purely datapath: no handshake and no state beyond the output registers.

Parameters:
- p_width, 22, bit width of each operand and of o_result; legal range 1..64.

Ports:
- i_clk  input  1  single clock; rising-edge active.
- i_rst_n  input  1  asynchronous active-low reset.
- i_a  input  p_width  operand A, unsigned.
- i_b  input  p_width  operand B, unsigned.
- i_c  input  p_width  operand C, unsigned.
- o_result  output  p_width  registered maximum of A, B, C.
- o_index  output  [3:1]  registered one-hot winner: bit1 = A, bit2 = B, bit3 = C.

Behaviour:
- Reset: i_rst_n low asynchronously clears o_result to 0 and o_index to 3'b000. Outputs hold these values while reset is asserted. The first update occurs on the first rising edge after release.
- Comparison: all operands are unsigned, with full-width magnitude compare and no truncation.
- Pair stage: compare A vs B; winner AB = A if A >= B, else B.
- Final stage: compare AB vs C; final winner = AB if AB >= C, else C.
- Tie rule: priority A > B > C, so the lowest-numbered input wins among equal maxima.
  - Equal A, B, C → index 3'b001.
  - A == C > B → 3'b001.
  - B == C > A → 3'b010.
- o_index: exactly one bit is set in every cycle after reset, including all-zero inputs (index 3'b001, result 0).
- o_result: always equals the input selected by o_index, sampled on the same edge.
- Latency: 1 clock. Inputs sampled at rising edge N appear on the outputs after edge N.
- Throughput: one new comparison per cycle. Outputs update every edge whether or not the inputs changed.
- Inputs changing mid-cycle have no effect until the next edge.
- Reset mid-operation: outputs clear immediately and the in-flight result is discarded.
- No X propagation is allowed from reset: all registers have reset values.

Optional Feature:
- Macro: COMPARATOR_3IN_PIPE_EN.
- Defined:
  - Inserts a register stage after the A/B pair compare. The AB winner value, its 2-bit index, and a delayed copy of C are registered.
  - Latency becomes 2 clocks; throughput stays at 1 per cycle.
  - All pipeline registers reset to 0, and the intermediate index resets to "A".
  - Outputs still reset to 0 / 3'b000 and are valid from the second edge after reset release.
- Undefined: single-stage behaviour as above, with latency 1.
- Tie rules and the one-hot encoding are identical in both modes.

Decomposition:
- Package comparator_pkg:
  - One-hot constants IDX_NONE = 3'b000, IDX_A = 3'b001, IDX_B = 3'b010, IDX_C = 3'b100.
  - Default width constant COMP_WIDTH_DEFAULT = 22.
- Sub-module cmp_max2:
  - Combinational two-operand unsigned max, parameterised by p_width.
  - Outputs the max value and sel (0 = first operand wins, used when first >= second).
  - Instantiated twice: A vs B, then AB vs C.
  - The top level forms o_index from the two sel bits and owns all registers and the pipeline option.

Test Plan:
- Reset with A=B=C=0 held for 10 ns, then released → o_result=0, o_index=000 during reset. After the first edge: o_result=0, o_index=001.
- A=3, B=2, C=1 → o_result=3, o_index=001. A=6, B=7, C=4 → 7, 010. A=5, B=4, C=7 → 7, 100.
- Ties:
  - 10/11/11 → 11, 010.
  - 12/12/11 → 12, 001.
  - 15/15/16 → 16, 100.
  - 18/18/18 → 18, 001.
  - 21/20/21 → 21, 001.
  - 32/33/33 → 33, 010.
- Extremes with p_width=22: A=0, B=C=22'h3FFFFF → 22'h3FFFFF, 010. A=22'h3FFFFF, B=C=0 → 22'h3FFFFF, 001.
- Latency check: change inputs every cycle; the outputs must match the reference max/index delayed by exactly 1 edge (2 edges with COMPARATOR_3IN_PIPE_EN). Assert a one-hot o_index on every cycle after reset.
- Mid-run reset: with A=33, B=33, C=33 active, pulse i_rst_n low between edges → outputs drop to 0/000 immediately, without waiting for a clock. They recover to 33/001 one edge after release.
